// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: PS/2 key decode, joystick merge, rotate remap,
// coin pulse stretch and DIP byte bank for arcade cores.
// Ports: clk_sys, reset_n (async, active-low); ps2_key, joystick, rotate,
// ioctl_wr/index/addr/dout in; btn (8 bits per player), dip (byte bank) out.
// Optional macro INPUT_AUTOFIRE_EN adds the autofire input and gates fire
// with a free-running square wave.
module arcade_input_ctrl #(
    parameter int NUM_PLAYERS       = 2,
    parameter int NUM_DIP_BYTES     = 8,
    parameter int COIN_PULSE_CYCLES = 1200000,
    parameter int AUTOFIRE_PERIOD   = 600000
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [10:0]                ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]  joystick,
    input  logic                       rotate,
`ifdef INPUT_AUTOFIRE_EN
    input  logic                       autofire,
`endif
    input  logic                       ioctl_wr,
    input  logic [7:0]                 ioctl_index,
    input  logic [24:0]                ioctl_addr,
    input  logic [7:0]                 ioctl_dout,
    output logic [8*NUM_PLAYERS-1:0]   btn,
    output logic [8*NUM_DIP_BYTES-1:0] dip
);

    localparam int CW = $clog2(COIN_PULSE_CYCLES + 1);

    logic            tog_q;
    logic            key_ev;
    logic [1:0][7:0] hit;
    logic [1:0][7:0] kstate;
    logic            fire_gate;
    logic            unused_k;

    assign key_ev   = ps2_key[10] ^ tog_q;
    assign unused_k = ^kstate[1];

    always_comb begin
        hit = '0;
        unique case (ps2_key[7:0])
            8'h75:        hit[0][3] = 1'b1;
            8'h72:        hit[0][2] = 1'b1;
            8'h6B:        hit[0][1] = 1'b1;
            8'h74:        hit[0][0] = 1'b1;
            8'h29, 8'h14: hit[0][4] = 1'b1;
            8'h11:        hit[0][5] = 1'b1;
            8'h16, 8'h05: hit[0][6] = 1'b1;
            8'h2E:        hit[0][7] = 1'b1;
            8'h2D:        hit[1][3] = 1'b1;
            8'h2B:        hit[1][2] = 1'b1;
            8'h23:        hit[1][1] = 1'b1;
            8'h34:        hit[1][0] = 1'b1;
            8'h1C:        hit[1][4] = 1'b1;
            8'h1B:        hit[1][5] = 1'b1;
            8'h1E, 8'h06: hit[1][6] = 1'b1;
            8'h36:        hit[1][7] = 1'b1;
            default:      ;
        endcase
        // Only the four arrow codes accept the extended prefix.
        if (ps2_key[8]) begin
            hit[0][7:4] = '0;
            hit[1]      = '0;
        end
    end

    // Aliased keys share a bit, so the latest event on either one wins.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q  <= 1'b0;
            kstate <= '0;
        end else begin
            tog_q <= ps2_key[10];
            if (key_ev) begin
                for (int p = 0; p < 2; p++) begin
                    kstate[p] <= (kstate[p] & ~hit[p])
                               | (hit[p] & {8{ps2_key[9]}});
                end
            end
        end
    end

`ifdef INPUT_AUTOFIRE_EN
    localparam int AW = $clog2(2 * AUTOFIRE_PERIOD);

    logic [AW-1:0] af_q;
    logic          af_wave;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_q <= '0;
        end else if (af_q == AW'(2 * AUTOFIRE_PERIOD - 1)) begin
            af_q <= '0;
        end else begin
            af_q <= af_q + 1'b1;
        end
    end

    // High for the first half-period after each wrap.
    assign af_wave   = af_q < AW'(AUTOFIRE_PERIOD);
    assign fire_gate = ~autofire | af_wave;
`else
    localparam int unused_af_period = AUTOFIRE_PERIOD;

    assign fire_gate = 1'b1;
`endif

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
        logic [7:0]    kb;
        logic [7:0]    raw;
        logic [3:0]    dir;
        logic          coin_prev;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          coin_q;
        logic [6:0]    btn_q;
        logic          unused_hi;

        if (p < 2) begin : g_kb
            assign kb = kstate[p];
        end else begin : g_nokb
            assign kb = '0;
        end

        assign unused_hi = ^joystick[16*p+8 +: 8];
        assign raw       = kb | joystick[16*p +: 8];

        // Rotated: up<-left, down<-right, left<-down, right<-up.
        assign dir = rotate ? {raw[1], raw[0], raw[2], raw[3]}
                            : raw[3:0];

        // Edges during an active pulse are dropped, never queued.
        always_comb begin
            cnt_d = cnt_q;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (raw[7] && !coin_prev) begin
                cnt_d = CW'(COIN_PULSE_CYCLES);
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                coin_prev <= 1'b0;
                cnt_q     <= '0;
                coin_q    <= 1'b0;
                btn_q     <= '0;
            end else begin
                coin_prev <= raw[7];
                cnt_q     <= cnt_d;
                coin_q    <= cnt_d != '0;
                btn_q     <= {raw[6:5], raw[4] & fire_gate, dir};
            end
        end

        assign btn[8*p +: 8] = {coin_q, btn_q};
    end

    logic [7:0] dip_q [NUM_DIP_BYTES];
    logic       dip_we;

    assign dip_we = ioctl_wr && ioctl_index == 8'd254
                 && ioctl_addr[24:3] == '0
                 && {1'b0, ioctl_addr[2:0]} < 4'(NUM_DIP_BYTES);

    for (genvar k = 0; k < NUM_DIP_BYTES; k++) begin : g_dip
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                dip_q[k] <= 8'hFF;
            end else if (dip_we && ioctl_addr[2:0] == 3'(k)) begin
                dip_q[k] <= ioctl_dout;
            end
        end

        assign dip[8*k +: 8] = dip_q[k];
    end

endmodule
